// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the video RAM slave port between the text-mode
// scanline fetcher (video) and the CPU.
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   v_cyc_i, v_adr_i    video request / byte address
//   v_dat_o, v_ack_o    video read data / transfer done
//   c_cyc_i, c_stb_i    CPU request (both high = request)
//   c_we_i, c_sel_i     CPU write enable / byte selects
//   c_adr_i, c_dat_i    CPU address / write data
//   c_dat_o, c_ack_o    CPU read data / transfer done
//   c_err_o             CPU transfer aborted by timeout
//   s_*                 slave bus toward the video RAM
//   gnt_o               01 video, 10 CPU, 00 idle
//   timeout_o           sticky: some transfer timed out
//
// Video wins by default. After MAX_VID_STREAK video grants while the CPU
// waits, the CPU gets one grant. Each grant covers one transfer and is
// bounded by TIMEOUT cycles.

`timescale 1ns/1ps

module vram_arbiter #(
   parameter int unsigned MAX_VID_STREAK = 8,
   parameter int unsigned TIMEOUT        = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,

   input  logic        v_cyc_i,
   input  logic [31:0] v_adr_i,
   output logic [31:0] v_dat_o,
   output logic        v_ack_o,

   input  logic        c_cyc_i,
   input  logic        c_stb_i,
   input  logic        c_we_i,
   input  logic [3:0]  c_sel_i,
   input  logic [31:0] c_adr_i,
   input  logic [31:0] c_dat_i,
   output logic [31:0] c_dat_o,
   output logic        c_ack_o,
   output logic        c_err_o,

   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,

   output logic [1:0]  gnt_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_VID  = 2'd1,
      ST_CPU  = 2'd2
   } state_e;

   localparam logic [7:0]  STREAK_MAX = 8'(MAX_VID_STREAK);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  streak_q, streak_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        timeout_q, timeout_d;

   logic v_req;
   logic c_req;
   logic own_req;
   logic granted;
   logic tmo_last;
   logic tmo_fire;
   logic cpu_turn;

   assign v_req   = v_cyc_i;
   assign c_req   = c_cyc_i & c_stb_i;
   assign granted = (state_q != ST_IDLE);

   // Request of whichever master currently owns the slave.
   always_comb begin
      own_req = 1'b0;
      unique case (state_q)
         ST_VID:  own_req = v_req;
         ST_CPU:  own_req = c_req;
         default: own_req = 1'b0;
      endcase
   end

   // Last allowed grant cycle: the slave cycle is withdrawn here.
   assign tmo_last = granted & (tmo_cnt_q == TMO_LAST);

   // A late ack in the last cycle still completes normally, and a
   // master that already dropped its request gets no ack at all.
   assign tmo_fire = tmo_last & own_req & ~s_ack_i;

   // CPU takes the slot once the video streak limit is reached.
   assign cpu_turn = c_req & (~v_req | (streak_q == STREAK_MAX));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         streak_q  <= '0;
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         streak_q  <= streak_d;
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      streak_d  = streak_q;
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
            if (cpu_turn) begin
               state_d  = ST_CPU;
               streak_d = '0;
            end else if (v_req) begin
               state_d = ST_VID;
               if (c_req && (streak_q < STREAK_MAX))
                  streak_d = streak_q + 8'd1;
            end
            // CPU not waiting: the streak is meaningless.
            if (!c_req)
               streak_d = '0;
         end

         ST_VID,
         ST_CPU: begin
            if (s_ack_i || !own_req) begin
               state_d = ST_IDLE;
            end else if (tmo_last) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus steering
   always_comb begin
      v_dat_o = '0;
      v_ack_o = 1'b0;
      c_dat_o = '0;
      c_ack_o = 1'b0;
      c_err_o = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      gnt_o   = 2'b00;

      unique case (state_q)
         ST_VID: begin
            gnt_o   = 2'b01;
            s_cyc_o = v_cyc_i & ~tmo_last;
            s_stb_o = v_cyc_i & ~tmo_last;
            s_sel_o = 4'hF;
            s_adr_o = v_adr_i;
            // Fetcher has no error input: a timeout
            // completes with zero data instead.
            v_ack_o = s_ack_i | tmo_fire;
            v_dat_o = tmo_fire ? 32'h0 : s_dat_i;
         end

         ST_CPU: begin
            gnt_o   = 2'b10;
            s_cyc_o = c_cyc_i & ~tmo_last;
            s_stb_o = c_stb_i & ~tmo_last;
            s_we_o  = c_we_i;
            s_sel_o = c_sel_i;
            s_adr_o = c_adr_i;
            s_dat_o = c_dat_i;
            c_ack_o = s_ack_i;
            c_err_o = tmo_fire;
            c_dat_o = s_dat_i;
         end

         default: begin
            gnt_o = 2'b00;
         end
      endcase
   end

   assign timeout_o = timeout_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter with
// MAX_VID_STREAK=8 and TIMEOUT=4.

`timescale 1ns/1ps

module tb_vram_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        v_cyc_i;
   logic [31:0] v_adr_i;
   logic [31:0] v_dat_o;
   logic        v_ack_o;
   logic        c_cyc_i;
   logic        c_stb_i;
   logic        c_we_i;
   logic [3:0]  c_sel_i;
   logic [31:0] c_adr_i;
   logic [31:0] c_dat_i;
   logic [31:0] c_dat_o;
   logic        c_ack_o;
   logic        c_err_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic [1:0]  gnt_o;
   logic        timeout_o;

   int n_tot = 0;
   int n_bad = 0;

   vram_arbiter #(
      .MAX_VID_STREAK(8),
      .TIMEOUT(4)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .v_cyc_i(v_cyc_i),
      .v_adr_i(v_adr_i),
      .v_dat_o(v_dat_o),
      .v_ack_o(v_ack_o),
      .c_cyc_i(c_cyc_i),
      .c_stb_i(c_stb_i),
      .c_we_i(c_we_i),
      .c_sel_i(c_sel_i),
      .c_adr_i(c_adr_i),
      .c_dat_i(c_dat_i),
      .c_dat_o(c_dat_o),
      .c_ack_o(c_ack_o),
      .c_err_o(c_err_o),
      .s_cyc_o(s_cyc_o),
      .s_stb_o(s_stb_o),
      .s_we_o(s_we_o),
      .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i),
      .gnt_o(gnt_o),
      .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0] seq [18];
      int got_n;

      rst_i   = 1'b1;
      v_cyc_i = 1'b0;
      v_adr_i = '0;
      c_cyc_i = 1'b0;
      c_stb_i = 1'b0;
      c_we_i  = 1'b0;
      c_sel_i = '0;
      c_adr_i = '0;
      c_dat_i = '0;
      s_dat_i = '0;
      s_ack_i = 1'b0;

      // reset state
      #3;
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_cyc", s_cyc_o, 1'b0);
      chk("rst_tmo", timeout_o, 1'b0);
      chk("rst_vack", v_ack_o, 1'b0);
      chk("rst_cack", c_ack_o, 1'b0);
      edge1();
      edge1();
      rst_i = 1'b0;
      edge1();

      // ack in idle is ignored
      s_ack_i = 1'b1;
      #1;
      chk("idle_vack", v_ack_o, 1'b0);
      chk("idle_cack", c_ack_o, 1'b0);
      edge1();
      chk("idle_gnt", gnt_o, 2'b00);
      s_ack_i = 1'b0;

      // video only, zero-wait slave
      v_cyc_i = 1'b1;
      v_adr_i = 32'h100;
      #1;
      chk("v_pre_gnt", gnt_o, 2'b00);
      edge1();
      s_ack_i = 1'b1;
      s_dat_i = 32'hA5A5_0102;
      #1;
      chk("v_gnt", gnt_o, 2'b01);
      chk("v_cyc", s_cyc_o, 1'b1);
      chk("v_adr", s_adr_o, 32'h100);
      chk("v_sel", s_sel_o, 4'hF);
      chk("v_we", s_we_o, 1'b0);
      chk("v_ack", v_ack_o, 1'b1);
      chk("v_dat", v_dat_o, 32'hA5A5_0102);
      chk("v_cack", c_ack_o, 1'b0);
      edge1();
      v_cyc_i = 1'b0;
      s_ack_i = 1'b0;
      s_dat_i = '0;
      #1;
      chk("v_post_gnt", gnt_o, 2'b00);
      chk("v_post_ack", v_ack_o, 1'b0);
      edge1();

      // CPU write, one wait state
      c_cyc_i = 1'b1;
      c_stb_i = 1'b1;
      c_we_i  = 1'b1;
      c_adr_i = 32'h40;
      c_sel_i = 4'h3;
      c_dat_i = 32'h1234;
      edge1();
      #1;
      chk("cw_gnt", gnt_o, 2'b10);
      chk("cw_we", s_we_o, 1'b1);
      chk("cw_adr", s_adr_o, 32'h40);
      chk("cw_sel", s_sel_o, 4'h3);
      chk("cw_dat", s_dat_o, 32'h1234);
      chk("cw_cyc", s_cyc_o, 1'b1);
      chk("cw_noack", c_ack_o, 1'b0);
      edge1();
      s_ack_i = 1'b1;
      #1;
      chk("cw_ack", c_ack_o, 1'b1);
      chk("cw_vack", v_ack_o, 1'b0);
      edge1();
      c_cyc_i = 1'b0;
      c_stb_i = 1'b0;
      c_we_i  = 1'b0;
      s_ack_i = 1'b0;
      #1;
      chk("cw_post_gnt", gnt_o, 2'b00);
      edge1();

      // ack arriving in the last timeout cycle wins
      c_cyc_i = 1'b1;
      c_stb_i = 1'b1;
      c_adr_i = 32'h48;
      c_sel_i = 4'hF;
      edge1();
      #1;
      chk("col_cyc", s_cyc_o, 1'b1);
      edge1();
      edge1();
      edge1();
      s_ack_i = 1'b1;
      s_dat_i = 32'h77;
      #1;
      chk("col_ack", c_ack_o, 1'b1);
      chk("col_err", c_err_o, 1'b0);
      chk("col_dat", c_dat_o, 32'h77);
      edge1();
      c_cyc_i = 1'b0;
      c_stb_i = 1'b0;
      s_ack_i = 1'b0;
      #1;
      chk("col_tmo", timeout_o, 1'b0);
      chk("col_gnt", gnt_o, 2'b00);
      edge1();

      // CPU read timeout
      c_cyc_i = 1'b1;
      c_stb_i = 1'b1;
      c_adr_i = 32'h44;
      s_dat_i = 32'hDEAD_BEEF;
      for (int k = 0; k < 3; k++) begin
         edge1();
         #1;
         chk($sformatf("to_cyc%0d", k), s_cyc_o, 1'b1);
         chk($sformatf("to_err%0d", k), c_err_o, 1'b0);
      end
      edge1();
      #1;
      chk("to_lastcyc", s_cyc_o, 1'b0);
      chk("to_err", c_err_o, 1'b1);
      chk("to_ack", c_ack_o, 1'b0);
      chk("to_tmo_pre", timeout_o, 1'b0);
      chk("to_gnt", gnt_o, 2'b10);
      edge1();
      c_cyc_i = 1'b0;
      c_stb_i = 1'b0;
      #1;
      chk("to_tmo", timeout_o, 1'b1);
      chk("to_err_pulse", c_err_o, 1'b0);
      chk("to_idle", gnt_o, 2'b00);

      // video afterwards is served normally
      v_cyc_i = 1'b1;
      v_adr_i = 32'h104;
      edge1();
      s_ack_i = 1'b1;
      s_dat_i = 32'h55;
      #1;
      chk("tv_gnt", gnt_o, 2'b01);
      chk("tv_ack", v_ack_o, 1'b1);
      chk("tv_dat", v_dat_o, 32'h55);
      chk("tv_tmo", timeout_o, 1'b1);
      edge1();
      v_cyc_i = 1'b0;
      s_ack_i = 1'b0;
      edge1();

      // video timeout completes with zero data
      s_dat_i = 32'hFFFF_FFFF;
      v_cyc_i = 1'b1;
      edge1();
      edge1();
      edge1();
      #1;
      chk("vt_cyc", s_cyc_o, 1'b1);
      edge1();
      #1;
      chk("vt_ack", v_ack_o, 1'b1);
      chk("vt_dat", v_dat_o, 32'h0);
      chk("vt_cyc_last", s_cyc_o, 1'b0);
      edge1();
      v_cyc_i = 1'b0;
      #1;
      chk("vt_gnt", gnt_o, 2'b00);
      chk("vt_ack_pulse", v_ack_o, 1'b0);
      edge1();

      // CPU drops request: abort without ack
      s_dat_i = '0;
      c_cyc_i = 1'b1;
      c_stb_i = 1'b1;
      edge1();
      c_cyc_i = 1'b0;
      #1;
      chk("ab_cyc", s_cyc_o, 1'b0);
      chk("ab_ack", c_ack_o, 1'b0);
      chk("ab_err", c_err_o, 1'b0);
      edge1();
      c_stb_i = 1'b0;
      #1;
      chk("ab_gnt", gnt_o, 2'b00);
      edge1();

      // starvation guard: 8 video then 1 CPU, repeating
      v_cyc_i = 1'b1;
      c_cyc_i = 1'b1;
      c_stb_i = 1'b1;
      s_ack_i = 1'b1;
      got_n   = 0;
      for (int k = 0; k < 100 && got_n < 18; k++) begin
         edge1();
         #1;
         if (gnt_o != 2'b00) begin
            seq[got_n] = gnt_o;
            got_n++;
         end
      end
      v_cyc_i = 1'b0;
      c_cyc_i = 1'b0;
      c_stb_i = 1'b0;
      s_ack_i = 1'b0;
      chk("st_count", got_n, 18);
      for (int i = 0; i < 18; i++) begin
         chk($sformatf("st_g%0d", i), seq[i],
             ((i % 9) == 8) ? 2'b10 : 2'b01);
      end
      edge1();
      edge1();
      #1;
      chk("st_idle", gnt_o, 2'b00);

      // reset during a video grant
      v_cyc_i = 1'b1;
      v_adr_i = 32'h200;
      edge1();
      #1;
      chk("rm_gnt", gnt_o, 2'b01);
      s_ack_i = 1'b1;
      #1;
      rst_i = 1'b1;
      #1;
      chk("rm_cyc", s_cyc_o, 1'b0);
      chk("rm_gnt0", gnt_o, 2'b00);
      chk("rm_vack", v_ack_o, 1'b0);
      chk("rm_tmo", timeout_o, 1'b0);
      s_ack_i = 1'b0;
      edge1();
      rst_i = 1'b0;
      #1;
      chk("rm_rel_gnt", gnt_o, 2'b00);
      edge1();
      #1;
      chk("rm_regnt", gnt_o, 2'b01);
      chk("rm_adr", s_adr_o, 32'h200);
      v_cyc_i = 1'b0;
      edge1();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
